// File: rtl/vending_pkg.sv
// Shared types and constants for the single-product vending controller.
// Credit-tracking states plus the default price and coin input width.
package vending_pkg;

  localparam int DOL_W         = 3;
  localparam int STATE_W       = 3;
  localparam int PRICE_DEFAULT = 3;

  // State value equals the credit held; wider prices reuse unnamed codes.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    CR1  = 3'd1,
    CR2  = 3'd2
  } state_e;

endpackage

// File: rtl/vending_machine_if.sv
// Coin-in / vend-out bundle between the front-end, the controller and the dispenser.
// No backpressure: dol is a one-cycle presentation, change a one-cycle pulse.
interface vending_machine_if;
  import vending_pkg::*;

  logic [DOL_W-1:0] dol;
  logic             change;

  modport master (output dol, input change);
  modport slave  (input dol, output change);

endinterface

// File: rtl/vending_machine.sv
// Accumulates dollar credit and emits a registered one-cycle vend pulse at PRICE; 1-cycle latency.
// No backpressure: every nonzero dol is consumed each cycle, excess over PRICE is dropped.
module vending_machine
  import vending_pkg::*;
#(
  parameter int PRICE    = PRICE_DEFAULT,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  vending_machine_if.slave    bus
);

  state_e              state_q, state_d;
  logic                change_q, change_d;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W:0]   sum;

  assign credit = CREDIT_W'(state_q);

  always_comb begin
    state_d  = state_q;
    change_d = 1'b0;
    sum      = {1'b0, credit} + (CREDIT_W+1)'(bus.dol);
    if (bus.dol != '0) begin
      if (sum >= (CREDIT_W+1)'(PRICE)) begin
        // A single insertion vends at most once; any surplus is forfeited.
        state_d  = IDLE;
        change_d = 1'b1;
      end else begin
        state_d  = state_e'(STATE_W'(sum));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
    end
  end

  assign bus.change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed table-driven bench for vending_machine at PRICE=3.
// Each vector is one clock: inputs driven on the falling edge, change checked after the rising edge.
module tb_vending_machine;
  import vending_pkg::*;

  logic clk;
  logic reset;

  vending_machine_if vif ();

  vending_machine #(.PRICE(3), .CREDIT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] dol;
    logic       exp_change;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] d);
    @(negedge clk);
    reset   = r;
    vif.dol = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] d, input logic e);
    vec_t v;
    v.rst = r; v.dol = d; v.exp_change = e;
    vecs.push_back(v);
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    vif.dol = '0;

    // reset with a coin present: discarded, no vend on release
    add(1, 3'd3, 0); add(0, 3'd0, 0); add(0, 3'd0, 0);
    // three single dollars with gaps
    add(0, 3'd1, 0); add(0, 3'd0, 0); add(0, 3'd1, 0); add(0, 3'd0, 0);
    add(0, 3'd1, 1); add(0, 3'd0, 0);
    // exact price from idle
    add(0, 3'd3, 1); add(0, 3'd0, 0);
    // 2 then 1
    add(0, 3'd2, 0); add(0, 3'd0, 0); add(0, 3'd1, 1); add(0, 3'd0, 0);
    // 2 then 2 vends; surplus dropped so a following 1 does not vend
    add(0, 3'd2, 0); add(0, 3'd2, 1); add(0, 3'd0, 0); add(0, 3'd1, 0);
    add(0, 3'd0, 0); add(0, 3'd2, 1); add(0, 3'd0, 0);
    // large values vend once each
    add(0, 3'd5, 1); add(0, 3'd0, 0); add(0, 3'd6, 1); add(0, 3'd0, 0);
    add(0, 3'd7, 1); add(0, 3'd0, 0); add(0, 3'd1, 0); add(0, 3'd0, 0);
    add(0, 3'd1, 0); add(0, 3'd1, 1); add(0, 3'd0, 0);
    // reset mid-accumulation clears credit
    add(0, 3'd2, 0); add(1, 3'd0, 0); add(0, 3'd1, 0); add(0, 3'd0, 0);
    add(0, 3'd2, 1); add(0, 3'd0, 0);
    // back-to-back vends keep change high
    add(0, 3'd3, 1); add(0, 3'd3, 1); add(0, 3'd0, 0);
    // held value counts every cycle
    add(0, 3'd1, 0); add(0, 3'd1, 0); add(0, 3'd1, 1); add(0, 3'd0, 0);
    // reset with coin present mid-accumulation, then restart from zero
    add(0, 3'd1, 0); add(1, 3'd2, 0); add(0, 3'd2, 0); add(0, 3'd1, 1);
    add(0, 3'd0, 0);
    // large value on top of partial credit
    add(0, 3'd2, 0); add(0, 3'd7, 1); add(0, 3'd0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].dol);
      check($sformatf("vec%0d_change", i), 32'(vif.change), 32'(vecs[i].exp_change));
    end

    // state tracking sequence
    step(1, 3'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_change", 32'(vif.change), 0);
    step(0, 3'd2);
    check("cr2_state", 32'(dut.state_q), 32'(CR2));
    check("cr2_change", 32'(vif.change), 0);
    step(0, 3'd0);
    check("cr2_hold", 32'(dut.state_q), 32'(CR2));
    step(0, 3'd1);
    check("vend_change", 32'(vif.change), 1);
    check("vend_state", 32'(dut.state_q), 32'(IDLE));
    step(0, 3'd1);
    check("cr1_state", 32'(dut.state_q), 32'(CR1));
    check("cr1_change", 32'(vif.change), 0);
    step(1, 3'd7);
    check("rst_over_dol_change", 32'(vif.change), 0);
    check("rst_over_dol_state", 32'(dut.state_q), 32'(IDLE));

    // long idle
    for (int k = 0; k < 8; k++) begin
      step(0, 3'd0);
      check($sformatf("idle%0d_change", k), 32'(vif.change), 0);
    end
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
